// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: one-hot controller
// states, default operand width and the bit-counter width helper.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    TEST  = 5'b00010,
    ADD   = 5'b00100,
    SHIFT = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  // The counter must hold 0..w-1 and still compare against w-1 cleanly.
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEFAULT_COUNT_W = count_width(DEFAULT_W);

endpackage

// File: rtl/mul_control.sv
// One-hot controller for the shift-and-add multiplier: sequences the
// test/add/shift steps, counts processed bits and owns busy/stop.
module mul_control
  import shift_add_multiplier_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  output logic load,
  output logic add,
  output logic shift,
  output logic busy,
  output logic stop
);

  localparam int              CW   = count_width(W);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  state_t        state;
  logic [CW-1:0] count;

  // Load happens on the accepting edge itself, so it is decoded from the
  // current state and start rather than registered.
  assign load  = start && ((state == IDLE) || (state == DONE));
  assign add   = (state == ADD);
  assign shift = (state == SHIFT);

  // NOTE: every register in a clocked block uses <= so all flops update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      stop  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= TEST;
            count <= '0;
            busy  <= 1'b1;
            stop  <= 1'b0;
          end
        end
        TEST:  state <= q0 ? ADD : SHIFT;
        ADD:   state <= SHIFT;
        SHIFT: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            stop  <= 1'b1;
          end else begin
            state <= TEST;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          stop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/stop handshake.
// Datapath (A, Q, M, carry) lives here; sequencing lives in mul_control.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int w = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [w-1:0]   multiplicand,
  input  logic [w-1:0]   multiplier,
  output logic [2*w-1:0] product,
  output logic           busy,
  output logic           stop
);

  logic [w-1:0] a_reg;
  logic [w-1:0] q_reg;
  logic [w-1:0] m_reg;
  logic         c_reg;
  logic [w:0]   sum;
  logic         load;
  logic         add;
  logic         shift;

  mul_control #(.W(w)) u_control (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .q0    (q_reg[0]),
    .load  (load),
    .add   (add),
    .shift (shift),
    .busy  (busy),
    .stop  (stop)
  );

  // Widened by one bit so the carry out of A+M is never lost.
  assign sum     = {1'b0, a_reg} + {1'b0, m_reg};
  assign product = {a_reg, q_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
      c_reg <= 1'b0;
    end else if (load) begin
      a_reg <= '0;
      q_reg <= multiplier;
      m_reg <= multiplicand;
      c_reg <= 1'b0;
    end else if (add) begin
      {c_reg, a_reg} <= sum;
    end else if (shift) begin
      {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[w-1:1]};
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios with
// literal expectations plus randomized operands against a cycle-count model.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           stop;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.w(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .stop         (stop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start fixes the answer and the number of
  // edges until done (2w + popcount of the multiplier).
  bit             m_busy = 1'b0;
  bit             m_stop = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_stop = 1'b0;
      m_left = 0;
      m_prod = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_stop = 1'b0;
        m_left = 2 * W + $countones(multiplier);
        m_prod = (2*W)'(multiplicand) * (2*W)'(multiplier);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_stop = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_busy", busy, m_busy);
      check("model_stop", stop, m_stop);
      if (m_stop) check("model_product", product, m_prod);
    end
  end

  // Launch one multiply; optionally pulse start with 9*9 while busy.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [2*W-1:0] exp_prod,
                         input int poke_at, input string tag);
    int lat = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(negedge clk);
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    check({tag, "_accept_stop"}, stop, 1'b0);
    check({tag, "_accept_busy"}, busy, 1'b1);
    while (!stop && lat < 200) begin
      if (busy) busy_cnt++;
      if (lat == poke_at) begin
        start = 1'b1;
        multiplicand = 8'd9;
        multiplier = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_product"}, product, exp_prod);
  endtask

  initial begin
    #1;
    check("reset_product", product, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_stop", stop, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stop", stop, 1'b0);

    run_mul(8'd123, 8'd15, 20, 16'h0735, -1, "t1");
    run_mul(8'd255, 8'd255, 24, 16'hFE01, -1, "t2");
    run_mul(8'd200, 8'd0, 16, 16'h0000, -1, "t3a");
    run_mul(8'd0, 8'd170, 20, 16'h0000, -1, "t3b");

    run_mul(8'd123, 8'd15, 20, 16'd1845, 4, "t4");
    repeat (5) @(negedge clk);
    check("t4_stop_held", stop, 1'b1);
    check("t4_product_held", product, 16'd1845);

    run_mul(8'd7, 8'd6, 18, 16'd42, -1, "t5");

    // Asynchronous reset between edges 8 and 9 of an operation.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 8'd123;
    multiplier = 8'd15;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_product_async", product, 16'h0000);
    check("t6_busy_async", busy, 1'b0);
    check("t6_stop_async", stop, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(8'd3, 8'd5, 18, 16'd15, -1, "t6");

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      run_mul(a, b, 2 * W + $countones(b), (2*W)'(a) * (2*W)'(b), -1, "rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
